// File: rtl/accum_buffer_bank.sv
// Per-column accumulate/drain buffer behind the systolic array bottom row.
// Two-stage read-modify-write with same-index forwarding per column.
module accum_buffer_bank #(
  parameter int DEPTH         = 16,
  parameter int ARRAY_M       = 8,
  parameter int DATA_WIDTH    = 32,
  parameter int IDX_WIDTH     = $clog2(DEPTH),
  parameter int IDX_SET_WIDTH = IDX_WIDTH * ARRAY_M
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [IDX_SET_WIDTH-1:0]      idx_set,
  input  logic [ARRAY_M-1:0]            enable_set,
  input  logic                          drain_mode,
  input  logic [DATA_WIDTH*ARRAY_M-1:0] psum_in,
  output logic [DATA_WIDTH*ARRAY_M-1:0] out_data,
  output logic [ARRAY_M-1:0]            out_valid,
  output logic                          busy
);

  logic [ARRAY_M-1:0] s1_v_all;

  assign busy = |{s1_v_all, out_valid};

  for (genvar m = 0; m < ARRAY_M; m++) begin : g_col
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0]      vld;
    logic [IDX_WIDTH-1:0]  idx;
    logic [IDX_WIDTH-1:0]  s1_idx;
    logic                  en;
    logic                  hit;
    logic                  s1_v;
    logic                  s1_drain;
    logic [DATA_WIDTH-1:0] psum;
    logic [DATA_WIDTH-1:0] s1_psum;
    logic [DATA_WIDTH-1:0] s1_base;
    logic [DATA_WIDTH-1:0] s1_sum;
    logic [DATA_WIDTH-1:0] base;
    logic [DATA_WIDTH-1:0] od;
    logic                  ov;

    assign idx    = idx_set[IDX_WIDTH*m +: IDX_WIDTH];
    assign psum   = psum_in[DATA_WIDTH*m +: DATA_WIDTH];
    assign en     = enable_set[m];
    assign s1_sum = s1_base + s1_psum;
    assign hit    = s1_v && (s1_idx == idx);

    // S1 result wins over the array for the same index
    always_comb begin
      base = '0;
      if (hit) begin
        base = s1_drain ? '0 : s1_sum;
      end else if (vld[idx]) begin
        base = mem[idx];
      end
    end

    always_ff @(posedge clk) begin
      if (en) begin
        s1_idx   <= idx;
        s1_drain <= drain_mode;
        s1_psum  <= psum;
        s1_base  <= base;
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        s1_v <= 1'b0;
        vld  <= '0;
        ov   <= 1'b0;
        od   <= '0;
      end else begin
        s1_v <= en;
        ov   <= s1_v && s1_drain;
        if (s1_v && s1_drain) od <= s1_base;
        if (s1_v) vld[s1_idx] <= !s1_drain;
      end
    end

    always_ff @(posedge clk) begin
      if (!reset && s1_v && !s1_drain) mem[s1_idx] <= s1_sum;
    end

    assign s1_v_all[m] = s1_v;
    assign out_valid[m] = ov;
    assign out_data[DATA_WIDTH*m +: DATA_WIDTH] = od;
  end

endmodule

// File: tb/tb_accum_buffer_bank.sv
// Directed bench for accum_buffer_bank.
// A reference memory per column feeds a scoreboard of drain results.
module tb_accum_buffer_bank;
  localparam int M  = 8;
  localparam int D  = 16;
  localparam int DW = 32;
  localparam int IW = 4;

  logic            clk = 0;
  logic            reset = 1;
  logic [IW*M-1:0] idx_set = '0;
  logic [M-1:0]    enable_set = '0;
  logic            drain_mode = 0;
  logic [DW*M-1:0] psum_in = '0;
  logic [DW*M-1:0] out_data;
  logic [M-1:0]    out_valid;
  logic            busy;

  accum_buffer_bank dut (
    .clk(clk), .reset(reset), .idx_set(idx_set),
    .enable_set(enable_set), .drain_mode(drain_mode),
    .psum_in(psum_in), .out_data(out_data),
    .out_valid(out_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] d;
  } exp_t;

  exp_t        sbq [M][$];
  logic [31:0] model [M][D];
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  logic [3:0]  hi_seen = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      hi_seen = hi_seen | out_valid[7:4];
      for (int m = 0; m < M; m++) begin
        if (out_valid[m]) begin
          if (sbq[m].size() == 0) begin
            chk($sformatf("unexpected_valid_c%0d", m), 1, 0);
          end else begin
            exp_t e;
            e = sbq[m].pop_front();
            chk($sformatf("drain_data_c%0d", m),
                out_data[m*DW +: DW], e.d);
            chk($sformatf("drain_cycle_c%0d", m), cyc, e.cyc);
          end
        end
      end
    end
  end

  task automatic op(int m, int i, bit dr, logic [31:0] p);
    exp_t e;
    enable_set[m] = 1'b1;
    idx_set[m*IW +: IW] = i[IW-1:0];
    drain_mode = dr;
    psum_in[m*DW +: DW] = p;
    if (dr) begin
      e.cyc = cyc + 2;
      e.d = model[m][i];
      sbq[m].push_back(e);
      model[m][i] = '0;
    end else begin
      model[m][i] = model[m][i] + p;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    enable_set = '0;
    drain_mode = 0;
  endtask

  task automatic clr_model();
    for (int m = 0; m < M; m++)
      for (int i = 0; i < D; i++)
        model[m][i] = '0;
  endtask

  initial begin
    clr_model();
    // reset state
    tick();
    chk("rst_out_valid", {24'd0, out_valid}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_out_data_c0", out_data[0 +: DW], 0);
    chk("rst_out_data_c7", out_data[7*DW +: DW], 0);
    tick();
    reset = 0;
    tick();

    // col0 three passes of 5 over idx0..3, then drain
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < 4; i++) begin
        op(0, i, 0, 5);
        tick();
        if (p == 0 && i == 0) chk("busy_after_op", {31'd0, busy}, 1);
      end
    for (int i = 0; i < 4; i++) begin
      op(0, i, 1, 0);
      tick();
    end
    repeat (3) tick();

    // skewed diagonal on cols 0-3
    hi_seen = '0;
    for (int t = 0; t < 7; t++) begin
      for (int m = 0; m < 4; m++)
        if (t - m >= 0 && t - m < 4) op(m, t - m, 0, m + 1);
      tick();
    end
    for (int t = 0; t < 7; t++) begin
      for (int m = 0; m < 4; m++)
        if (t - m >= 0 && t - m < 4) op(m, t - m, 1, 0);
      tick();
    end
    repeat (3) tick();
    chk("skew_hi_cols_quiet", {28'd0, hi_seen}, 0);

    // back-to-back accumulate forwarding
    op(2, 5, 0, 7);
    tick();
    op(2, 5, 0, 32'hFFFF_FFFD);
    tick();
    op(2, 5, 1, 0);
    tick();
    repeat (3) tick();

    // drain twice then re-accumulate right after
    op(0, 1, 0, 9);
    tick();
    op(0, 1, 1, 0);
    tick();
    op(0, 1, 1, 0);
    tick();
    op(0, 1, 0, 2);
    tick();
    op(0, 1, 1, 0);
    tick();
    repeat (3) tick();

    // reset in the middle of an accumulate burst
    for (int t = 0; t < 3; t++) begin
      for (int m = 0; m < M; m++) op(m, t, 0, 100);
      tick();
    end
    for (int m = 0; m < M; m++) op(m, 3, 0, 100);
    reset = 1;
    tick();
    chk("midrst_out_valid", {24'd0, out_valid}, 0);
    chk("midrst_busy", {31'd0, busy}, 0);
    tick();
    chk("midrst_busy2", {31'd0, busy}, 0);
    reset = 0;
    clr_model();
    for (int i = 0; i < D; i++) begin
      for (int m = 0; m < M; m++) op(m, i, 1, 0);
      tick();
    end
    repeat (3) tick();

    // wrap without saturation
    op(0, 0, 0, 32'h7FFF_FFFF);
    tick();
    op(0, 0, 0, 1);
    tick();
    op(0, 0, 1, 0);
    tick();
    repeat (4) tick();

    for (int m = 0; m < M; m++)
      chk($sformatf("scoreboard_empty_c%0d", m), sbq[m].size(), 0);
    chk("final_busy", {31'd0, busy}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
